muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the execute stage of the pipelined MIPS core. It generalises the fixed-width, fixed-latency HI/LO unit in three ways: configurable operand width and per-class latencies, accumulate modes (MADD/MADDU/MSUB/MSUBU), and start suppression for instructions cancelled by an exception or interrupt. The hazard controller stalls on `busy`, and the execute stage reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: busy cycles for multiply and accumulate ops; must be ≥1.
- DIV_CYCLES, 10: busy cycles for divide ops; must be ≥1.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock.
- start  in  1  one-cycle request; op and operands valid in the same cycle.
- op  in  4  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 0 and 11–15 are no-ops.
- a  in  WIDTH  rs operand, post-forwarding.
- b  in  WIDTH  rt operand, post-forwarding.
- flush  in  1  execute-stage instruction cancelled (IntReq/exception); gates start.
- busy  out  1  operation in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Accepted start: start=1 & flush=0 & busy=0 & op in 1..10. Start while busy is ignored; the controller must not issue one.
- Registers: hi, lo, cnt (⌈log2(max latency+1)⌉ bits), res_hi, res_lo (pending result).
- MTHI/MTLO: write a to hi/lo at the accepting edge. No busy, cnt untouched.
- MULT/MULTU: {res_hi,res_lo} = signed/unsigned a*b (2*WIDTH bits). cnt ← MULT_CYCLES.
- MADD/MADDU: {res_hi,res_lo} = {hi,lo} + product. MSUB/MSUBU: {hi,lo} − product. Product signedness follows the op. Arithmetic is modulo 2^(2*WIDTH). {hi,lo} is sampled at the start edge, which is safe because hi/lo cannot change while busy. cnt ← MULT_CYCLES.
- DIV: res_lo = a/b truncated toward zero; res_hi = remainder with the sign of the dividend. DIVU: unsigned. cnt ← DIV_CYCLES.
- DIV overflow (a=most-negative, b=−1): res_lo = most-negative, res_hi = 0.
- Divide by zero (DIV/DIVU, b=0): the op is accepted and busy runs the full DIV_CYCLES, but hi/lo are left unchanged at completion.
- Countdown: cnt decrements each edge while nonzero. On the edge where cnt goes 1→0, hi←res_hi and lo←res_lo (unless the op was a divide by zero).
- busy = (cnt ≠ 0), registered-derived with no combinational path from start.
- flush: only suppresses acceptance in the same cycle. It does not abort an operation already in progress, because that instruction has retired past E and must complete.
- Reset at any time, including mid-operation: cnt=0, busy=0, hi=0, lo=0, res_hi=res_lo=0. The pending result is discarded.

## Timing
- Accepting edge E0. busy is high from E0 through edge E0+L, i.e. exactly L cycles (L = MULT_CYCLES or DIV_CYCLES).
- New hi/lo are visible in the cycle after busy falls, i.e. after edge E0+L.
- MTHI/MTLO: new value visible the cycle after E0; busy stays 0.
- Back-to-back: a new start may be accepted in the first cycle with busy=0.
- MFHI/MFLO in the cycle busy falls read the new value (registered at the same edge).
- Reset values: busy=0, hi=0, lo=0.

## Test plan
- Reset, then MULT a=0xFFFFFFFE (−2), b=3. Required: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001. Then MADDU a=1, b=1. Required: lo=0x00000002, hi unchanged.
- DIV a=−7, b=2. Required: busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0. Required: busy 10 cycles, hi/lo unchanged.
- DIV a=0x80000000, b=0xFFFFFFFF. Required: lo=0x80000000, hi=0. Then MSUB a=1, b=1 starting from {0,0x80000000}. Required: {hi,lo}={0,0x7FFFFFFF}.
- start with flush=1 (MULT 5×5, and separately MTHI 0x1234). Required: busy stays 0, hi/lo unchanged. Also: flush pulsed mid-operation. Required: the operation still completes.
- Assert reset 2 cycles into a DIV. Required: busy=0 and hi=lo=0 immediately (asynchronous). Also: re-run the MULT and DIV tests with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3; latency and results must scale accordingly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the execute stage.
// Results are computed at the accepting edge, held pending, and committed when the countdown expires.
module muldiv_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
      $error("muldiv_unit: MULT_CYCLES and DIV_CYCLES must be at least 1");
   end

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dz_q, dz_d;

   // ---------------------------------------------------------------- decode
   logic valid_op, is_mul, is_div, is_acc, is_sub, is_mthi, is_mtlo, op_signed;

   always_comb begin
      valid_op  = 1'b1;
      is_mul    = 1'b0;
      is_div    = 1'b0;
      is_acc    = 1'b0;
      is_sub    = 1'b0;
      is_mthi   = 1'b0;
      is_mtlo   = 1'b0;
      op_signed = 1'b0;
      unique case (op)
         OP_MULT:  begin is_mul = 1'b1; op_signed = 1'b1; end
         OP_MULTU: is_mul = 1'b1;
         OP_DIV:   begin is_div = 1'b1; op_signed = 1'b1; end
         OP_DIVU:  is_div = 1'b1;
         OP_MTHI:  is_mthi = 1'b1;
         OP_MTLO:  is_mtlo = 1'b1;
         OP_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; op_signed = 1'b1; end
         OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
         OP_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; op_signed = 1'b1; end
         OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
         default:  valid_op = 1'b0;
      endcase
   end

   // -------------------------------------------------------------- multiply
   // Extending both operands to 2*WIDTH makes the truncated product correct
   // for signed and unsigned ops alike.
   logic [2*WIDTH-1:0] a_ext, b_ext, product, hilo, mul_result;

   always_comb begin
      a_ext      = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      b_ext      = op_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
      product    = a_ext * b_ext;
      hilo       = {hi_q, lo_q};
      mul_result = product;
      if (is_acc) begin
         mul_result = is_sub ? (hilo - product) : (hilo + product);
      end
   end

   // ---------------------------------------------------------------- divide
   // Sign-magnitude division; most-negative / -1 falls out naturally as
   // quotient = most-negative, remainder = 0.
   logic             neg_a, neg_b, div_zero;
   logic [WIDTH-1:0] mag_a, mag_b, divisor, quo_u, rem_u, quo, rem;

   always_comb begin
      neg_a    = op_signed & a[WIDTH-1];
      neg_b    = op_signed & b[WIDTH-1];
      mag_a    = neg_a ? -a : a;
      mag_b    = neg_b ? -b : b;
      div_zero = (b == '0);
      divisor  = div_zero ? WIDTH'(1) : mag_b;
      quo_u    = mag_a / divisor;
      rem_u    = mag_a % divisor;
      quo      = (neg_a ^ neg_b) ? -quo_u : quo_u;
      rem      = neg_a ? -rem_u : rem_u;
   end

   // ------------------------------------------------------------ next state
   logic accept;

   assign accept = start & ~flush & ~busy & valid_op;

   always_comb begin
      // NOTE: every *_d gets a default hold value first so no path through this block can infer a latch.
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      cnt_d    = cnt_q;
      dz_d     = dz_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE && !dz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
         end
      end else if (accept) begin
         if (is_mthi) begin
            hi_d = a;
         end else if (is_mtlo) begin
            lo_d = a;
         end else if (is_div) begin
            res_hi_d = rem;
            res_lo_d = quo;
            dz_d     = div_zero;
            cnt_d    = DIV_LOAD;
         end else if (is_mul) begin
            {res_hi_d, res_lo_d} = mul_result;
            dz_d                 = 1'b0;
            cnt_d                = MULT_LOAD;
         end
      end
   end

   // ------------------------------------------------------------- registers
   // NOTE: state is updated only with non-blocking assignments so every flop samples the pre-edge values.
   // NOTE: the pending result is cleared on reset too, so a reset mid-operation leaves nothing to commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         cnt_q    <= '0;
         dz_q     <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         cnt_q    <= cnt_d;
         dz_q     <= dz_d;
      end
   end

   assign busy = (cnt_q != '0);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit (5/10 cycle) and a 16-bit (1/3 cycle) instance
// share stimulus; expected HI/LO and busy length come from a 64-bit reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start32, start16;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        flush;
   logic        busy32, busy16;
   logic [31:0] hi32, lo32;
   logic [15:0] hi16, lo16;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          sel;
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mhi[2];
   logic [31:0] mlo[2];

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy32), .hi(hi32), .lo(lo32));

   muldiv_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .op(op), .a(a[15:0]), .b(b[15:0]),
      .flush(flush), .busy(busy16), .hi(hi16), .lo(lo16));

   function automatic logic get_busy(input int sel);
      return (sel != 0) ? busy16 : busy32;
   endfunction

   function automatic logic [31:0] get_hi(input int sel);
      return (sel != 0) ? {16'h0, hi16} : hi32;
   endfunction

   function automatic logic [31:0] get_lo(input int sel);
      return (sel != 0) ? {16'h0, lo16} : lo32;
   endfunction

   function automatic longint sx(input logic [31:0] v, input int w);
      longint t;
      t = longint'(v) & ((longint'(1) << w) - 1);
      if (v[w-1]) t = t - (longint'(1) << w);
      return t;
   endfunction

   // Reference model: updates h/l in place and reports the expected busy length.
   function automatic void model(input int w, input int mc, input int dc, input logic [3:0] o,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 inout logic [31:0] h, inout logic [31:0] l, output int lat);
      logic [63:0] m, fm, acc, pu, ps, res;
      longint      sa, sbv, q, r;
      logic        mul;
      m   = (64'd1 << w) - 64'd1;
      fm  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      sa  = sx(av, w);
      sbv = sx(bv, w);
      acc = ((64'(h) & m) << w) | (64'(l) & m);
      pu  = (64'(av) & m) * (64'(bv) & m);
      ps  = sa * sbv;
      res = acc;
      mul = 1'b0;
      lat = 0;
      case (o)
         4'd1:  begin res = ps;       mul = 1'b1; end
         4'd2:  begin res = pu;       mul = 1'b1; end
         4'd7:  begin res = acc + ps; mul = 1'b1; end
         4'd8:  begin res = acc + pu; mul = 1'b1; end
         4'd9:  begin res = acc - ps; mul = 1'b1; end
         4'd10: begin res = acc - pu; mul = 1'b1; end
         4'd3: begin
            lat = dc;
            if ((64'(bv) & m) != 64'd0) begin
               q = sa / sbv;
               r = sa % sbv;
               h = 32'(64'(r) & m);
               l = 32'(64'(q) & m);
            end
         end
         4'd4: begin
            lat = dc;
            if ((64'(bv) & m) != 64'd0) begin
               h = 32'((64'(av) & m) % (64'(bv) & m));
               l = 32'((64'(av) & m) / (64'(bv) & m));
            end
         end
         4'd5:    h = 32'(64'(av) & m);
         4'd6:    l = 32'(64'(av) & m);
         default: ;
      endcase
      if (mul) begin
         lat = mc;
         res = res & fm;
         h   = 32'((res >> w) & m);
         l   = 32'(res & m);
      end
   endfunction

   // Issue one op on instance sel, push the expectation, wait for completion, pop and compare.
   task automatic run_op(input int sel, input logic [3:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic fl, input logic fl_mid, input string name);
      exp_t        e, got;
      logic [31:0] h, l;
      int          lat, n;
      h   = mhi[sel];
      l   = mlo[sel];
      lat = 0;
      if (!fl) begin
         if (sel != 0) model(16, 1, 3, o, av, bv, h, l, lat);
         else          model(32, 5, 10, o, av, bv, h, l, lat);
      end
      mhi[sel] = h;
      mlo[sel] = l;
      e.sel = sel; e.lat = lat; e.hi = h; e.lo = l; e.name = name;
      sb.push_back(e);

      op    = o;
      a     = av;
      b     = bv;
      flush = fl;
      if (sel != 0) start16 = 1'b1;
      else          start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      start16 = 1'b0;
      flush   = 1'b0;
      n = 0;
      while (get_busy(sel) && n < 64) begin
         n++;
         flush = fl_mid && (n == 2);
         @(posedge clk); #1;
      end
      flush = 1'b0;

      got = sb.pop_front();
      total++;
      if (n >= 64) begin
         bad++;
         $display("FAIL %s busy_timeout: busy still high after %0d cycles", got.name, n);
      end else if (n != got.lat) begin
         bad++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", got.name, n, got.lat);
      end
      total++;
      if (get_hi(got.sel) !== got.hi) begin
         bad++;
         $display("FAIL %s hi: got %h expected %h", got.name, get_hi(got.sel), got.hi);
      end
      total++;
      if (get_lo(got.sel) !== got.lo) begin
         bad++;
         $display("FAIL %s lo: got %h expected %h", got.name, get_lo(got.sel), got.lo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start32 = 1'b0; start16 = 1'b0; flush = 1'b0;
      op = 4'd0; a = '0; b = '0;
      mhi = '{32'h0, 32'h0};
      mlo = '{32'h0, 32'h0};
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy32, busy16, hi32, lo32, hi16, lo16} !== '0) begin
         bad++;
         $display("FAIL reset_values: got busy=%b/%b hi=%h/%h lo=%h/%h expected all zero",
                  busy32, busy16, hi32, hi16, lo32, lo16);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      run_op(0, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "mult32_neg2x3");
      total++;
      if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         bad++;
         $display("FAIL mult32_const: got %h_%h expected ffffffff_fffffffa", hi32, lo32);
      end
      run_op(0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu32_max");
      run_op(0, 4'd8, 32'd1, 32'd1, 1'b0, 1'b0, "maddu32_1x1");
      total++;
      if ({hi32, lo32} !== 64'hFFFF_FFFE_0000_0002) begin
         bad++;
         $display("FAIL maddu32_const: got %h_%h expected fffffffe_00000002", hi32, lo32);
      end
      run_op(1, 4'd1, 32'h0000_FFFE, 32'd3, 1'b0, 1'b0, "mult16_neg2x3");
      run_op(1, 4'd2, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, "multu16_max");
      run_op(1, 4'd8, 32'd1, 32'd1, 1'b0, 1'b0, "maddu16_1x1");
   endtask

   task automatic test_div();
      run_op(0, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div32_neg7by2");
      total++;
      if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         bad++;
         $display("FAIL div32_const: got %h_%h expected ffffffff_fffffffd", hi32, lo32);
      end
      run_op(0, 4'd4, 32'd7, 32'd0, 1'b0, 1'b0, "divu32_by_zero");
      run_op(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div32_overflow");
      run_op(0, 4'd9, 32'd1, 32'd1, 1'b0, 1'b0, "msub32_1x1");
      total++;
      if ({hi32, lo32} !== 64'h0000_0000_7FFF_FFFF) begin
         bad++;
         $display("FAIL msub32_const: got %h_%h expected 00000000_7fffffff", hi32, lo32);
      end
      run_op(1, 4'd3, 32'h0000_FFF9, 32'd2, 1'b0, 1'b0, "div16_neg7by2");
      run_op(1, 4'd4, 32'd7, 32'd0, 1'b0, 1'b0, "divu16_by_zero");
      run_op(1, 4'd3, 32'h0000_8000, 32'h0000_FFFF, 1'b0, 1'b0, "div16_overflow");
      run_op(1, 4'd9, 32'd1, 32'd1, 1'b0, 1'b0, "msub16_1x1");
   endtask

   task automatic test_flush();
      run_op(0, 4'd1, 32'd5, 32'd5, 1'b1, 1'b0, "mult32_flushed");
      run_op(0, 4'd5, 32'h1234, 32'd0, 1'b1, 1'b0, "mthi32_flushed");
      run_op(1, 4'd1, 32'd5, 32'd5, 1'b1, 1'b0, "mult16_flushed");
      run_op(0, 4'd3, 32'd1000, 32'd7, 1'b0, 1'b1, "div32_flush_mid");
      run_op(1, 4'd1, 32'd300, 32'd5, 1'b0, 1'b1, "mult16_flush_mid");
      run_op(0, 4'd5, 32'h1234, 32'd0, 1'b0, 1'b0, "mthi32");
      run_op(0, 4'd6, 32'h5678, 32'd0, 1'b0, 1'b0, "mtlo32");
      run_op(1, 4'd0, 32'd9, 32'd9, 1'b0, 1'b0, "nop16");
   endtask

   task automatic test_reset_mid();
      op = 4'd3; a = 32'd100; b = 32'd7;
      start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      total++;
      if ({busy32, hi32, lo32} !== '0) begin
         bad++;
         $display("FAIL reset_mid_async: got busy=%b hi=%h lo=%h expected 0", busy32, hi32, lo32);
      end
      mhi = '{32'h0, 32'h0};
      mlo = '{32'h0, 32'h0};
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      total++;
      if ({busy32, hi32, lo32} !== '0) begin
         bad++;
         $display("FAIL reset_mid_discard: got busy=%b hi=%h lo=%h expected 0", busy32, hi32, lo32);
      end
      run_op(0, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0, "div32_after_reset");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) begin
         int          sel;
         logic [3:0]  o;
         logic [31:0] av, bv;
         logic        fl;
         sel = $urandom_range(0, 1);
         o   = 4'($urandom_range(0, 12));
         av  = $urandom;
         bv  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         fl  = ($urandom_range(0, 7) == 0);
         run_op(sel, o, av, bv, fl, 1'b0, $sformatf("b2b_%0d_op%0d", i, o));
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
